// File: rtl/cache_pkg.sv
// Shared types and constants for the data cache and its helpers.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } cache_state_t;

  // RISC-V load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Address field widths below the index
  localparam int BYTE_OFFSET_BITS = 2;
  localparam int WORD_SEL_BITS    = 2;
  localparam int LINE_OFFSET_BITS = BYTE_OFFSET_BITS + WORD_SEL_BITS;
  localparam int WORDS_PER_LINE   = 1 << WORD_SEL_BITS;

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword of a word and sign/zero extends it.
module load_align
  import cache_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection and extension by load width
  always_comb begin
    byte_sel = 8'(word >> {byte_off, 3'b000});
    half_sel = byte_off[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data = {24'h0, byte_sel};
      F3_HU:   data = {16'h0, half_sel};
      F3_W:    data = word;
      default: data = word;
    endcase
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with 4-word lines.
module data_cache
  import cache_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int INDEX_BITS    = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_re,
  input  logic                     cpu_we,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  input  logic [2:0]               cpu_funct3,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic                     stall,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic [3:0]               mem_wstrb,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_ready
);

  localparam int SETS     = 1 << INDEX_BITS;
  localparam int TAG_BITS = ADDRESS_WIDTH - INDEX_BITS - LINE_OFFSET_BITS;

  cache_state_t state_q, state_d;
  logic [WORD_SEL_BITS-1:0] cnt_q;
  logic [SETS-1:0]          valid_q;
  logic [TAG_BITS-1:0]      tag_mem  [SETS];
  logic [DATA_WIDTH-1:0]    data_mem [SETS][WORDS_PER_LINE];

  logic [INDEX_BITS-1:0]    idx;
  logic [TAG_BITS-1:0]      tag;
  logic [WORD_SEL_BITS-1:0] wsel;
  logic                     hit;
  logic [DATA_WIDTH-1:0]    ld_data;
  logic [DATA_WIDTH-1:0]    st_data;
  logic [3:0]               st_strb;

  assign idx  = cpu_addr[INDEX_BITS+LINE_OFFSET_BITS-1:LINE_OFFSET_BITS];
  assign tag  = cpu_addr[ADDRESS_WIDTH-1:INDEX_BITS+LINE_OFFSET_BITS];
  assign wsel = cpu_addr[LINE_OFFSET_BITS-1:BYTE_OFFSET_BITS];
  assign hit  = valid_q[idx] && (tag_mem[idx] == tag);

  load_align u_load_align (
    .word     (data_mem[idx][wsel]),
    .byte_off (cpu_addr[BYTE_OFFSET_BITS-1:0]),
    .funct3   (cpu_funct3),
    .data     (ld_data)
  );

  // Store data replicated across lanes plus byte enables for the target lanes
  always_comb begin
    case (cpu_funct3)
      F3_B: begin
        st_data = {4{cpu_wdata[7:0]}};
        st_strb = 4'b0001 << cpu_addr[1:0];
      end
      F3_H: begin
        st_data = {2{cpu_wdata[15:0]}};
        st_strb = 4'b0011 << {cpu_addr[1], 1'b0};
      end
      default: begin
        st_data = cpu_wdata;
        st_strb = 4'b1111;
      end
    endcase
  end

  // Next state and all outputs; reset forces the quiet output set
  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    cpu_rdata = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {cpu_addr[ADDRESS_WIDTH-1:BYTE_OFFSET_BITS], 2'b00};
    mem_wdata = st_data;
    mem_wstrb = 4'b0000;
    if (rst) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_we) begin
            stall   = 1'b1;
            state_d = WRITE;
          end else if (cpu_re) begin
            if (hit) begin
              cpu_rdata = ld_data;
            end else begin
              stall   = 1'b1;
              state_d = FILL;
            end
          end
        end
        FILL: begin
          stall    = 1'b1;
          mem_req  = 1'b1;
          mem_addr = {cpu_addr[ADDRESS_WIDTH-1:LINE_OFFSET_BITS], cnt_q, 2'b00};
          if (mem_ready && cnt_q == 2'd3) state_d = IDLE;
        end
        WRITE: begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_wstrb = st_strb;
          stall     = !mem_ready;
          if (mem_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state, fill beat counter and per-set valid bits
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        cnt_q <= '0;
      end else if (state_q == FILL && mem_ready) begin
        cnt_q <= cnt_q + 2'd1;
        if (cnt_q == 2'd3) valid_q[idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; writes are suppressed while rst is high
  always_ff @(posedge clk) begin
    if (!rst && mem_ready) begin
      if (state_q == FILL) begin
        data_mem[idx][cnt_q] <= mem_rdata;
        if (cnt_q == 2'd3) tag_mem[idx] <= tag;
      end else if (state_q == WRITE && hit) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (st_strb[b]) data_mem[idx][wsel][8*b +: 8] <= st_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Randomized scoreboard bench for data_cache with a behavioural memory and cache model.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_re, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [2:0]  cpu_funct3;
  logic        stall, mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  data_cache #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .INDEX_BITS(6)) dut (
    .clk(clk), .rst(rst), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_funct3(cpu_funct3), .cpu_rdata(cpu_rdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int unsigned checks = 0;
  int unsigned passed = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endfunction

  // ---------------- backing memory (what the DUT talks to) ----------------
  logic [31:0] mem_arr [int unsigned];
  logic [31:0] ref_mem [int unsigned];

  function automatic logic [31:0] init_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] mem_read(logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_read(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  int          ready_mode = 0;   // 0 always ready, 1 fixed delay, 2 random
  int          fixed_delay = 3;
  int          wait_cnt = 0;
  logic [31:0] rd_log [$];
  int          wr_cnt = 0;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;

  // Memory responder: decides ready for the coming edge and logs the handshake
  always @(negedge clk) begin
    logic [31:0] w;
    if (rst || !mem_req) begin
      wait_cnt  = 0;
      mem_ready = ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
    end else begin
      case (ready_mode)
        0:       mem_ready = 1'b1;
        1:       mem_ready = (wait_cnt >= fixed_delay);
        default: mem_ready = ($urandom_range(0, 2) == 0);
      endcase
      if (mem_ready) begin
        wait_cnt = 0;
        if (mem_we) begin
          w = mem_read(mem_addr);
          for (int b = 0; b < 4; b++) if (mem_wstrb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
          mem_arr[mem_addr] = w;
          wr_cnt++;
          wr_addr = mem_addr;
          wr_data = mem_wdata;
          wr_strb = mem_wstrb;
        end else begin
          mem_rdata = mem_read(mem_addr);
          rd_log.push_back(mem_addr);
        end
      end else begin
        wait_cnt++;
        mem_rdata = $urandom;
      end
    end
  end

  // ---------------- reference cache model + scoreboard ----------------
  typedef struct {
    bit          is_load;
    logic [31:0] data;
    logic [31:0] line;
    int          beats;
    int          cycles;   // 0 = not checked
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } exp_t;

  exp_t        sb [$];
  bit          ref_valid [64];
  logic [31:0] ref_tag   [64];

  function automatic logic [31:0] ref_load(logic [31:0] w, logic [1:0] off, logic [2:0] f3);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  // Issue one request, queue its expected outcome, hold until the cache accepts it
  task automatic do_op(input bit we, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [31:0] wd);
    exp_t        e;
    int unsigned si, nb, st;
    logic [31:0] w;
    bit          done;
    si = (addr >> 4) & 63;
    e.line = addr & ~32'hF;
    e.waddr = addr & ~32'h3;
    e.is_load = !we;
    e.beats = 0;
    e.cycles = 0;
    e.data = 0;
    e.wdata = 0;
    e.wstrb = 0;
    if (we) begin
      nb = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
      st = (f3 == 3'b000) ? addr[1:0] : (f3 == 3'b001) ? {addr[1], 1'b0} : 0;
      e.wstrb = 4'(((1 << nb) - 1) << st);
      e.wdata = (nb == 1) ? {4{wd[7:0]}} : (nb == 2) ? {2{wd[15:0]}} : wd;
      w = ref_read(e.waddr);
      for (int b = 0; b < 4; b++) if (e.wstrb[b]) w[8*b +: 8] = e.wdata[8*b +: 8];
      ref_mem[e.waddr] = w;
    end else begin
      if (ref_valid[si] && ref_tag[si] == (addr >> 10)) begin
        e.cycles = 1;
      end else begin
        e.beats = 4;
        e.cycles = (ready_mode == 0) ? 6 : 0;
        ref_valid[si] = 1'b1;
        ref_tag[si] = addr >> 10;
      end
      e.data = ref_load(ref_read(e.waddr), addr[1:0], f3);
    end
    sb.push_back(e);
    cpu_re = !we || ($urandom_range(0, 1) == 1);   // store wins even with re high
    cpu_we = we;
    cpu_addr = addr;
    cpu_funct3 = f3;
    cpu_wdata = we ? wd : $urandom;
    done = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk); #3;
      if (!stall) done = 1;
    end
    if (!done) begin
      checks++;
      $display("FAIL request_timeout: addr 0x%08h still stalled after 200 cycles", addr);
      $display("%0d/%0d checks passed", passed, checks);
      $fatal(1, "request timeout");
    end
    @(posedge clk); #1;
    cpu_re = 0;
    cpu_we = 0;
  endtask

  int act_cycles = 0;

  // Monitor: on each accepted request compare against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst) begin
      act_cycles = 0;
    end else if (cpu_re || cpu_we) begin
      act_cycles++;
      if (!stall) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_completion: got completion at 0x%08h, expected none", cpu_addr);
        end else begin
          e = sb.pop_front();
          if (e.is_load) begin
            check("load_data", cpu_rdata, e.data);
            check("fill_beats", 32'(rd_log.size()), 32'(e.beats));
            for (int k = 0; k < rd_log.size() && k < 4; k++)
              check("fill_addr", rd_log[k], e.line + 32'(4 * k));
            if (e.cycles != 0) check("load_latency", 32'(act_cycles), 32'(e.cycles));
          end else begin
            check("write_count", 32'(wr_cnt), 32'd1);
            check("write_addr", wr_addr, e.waddr);
            check("write_strb", {28'h0, wr_strb}, {28'h0, e.wstrb});
            check("write_data", wr_data, e.wdata);
            check("store_no_fill", 32'(rd_log.size()), 32'd0);
          end
        end
        rd_log.delete();
        wr_cnt = 0;
        act_cycles = 0;
      end
    end
  end

  task automatic check_quiet(string tagname);
    check({tagname, "_stall"}, {31'h0, stall}, 32'd0);
    check({tagname, "_mem_req"}, {31'h0, mem_req}, 32'd0);
    check({tagname, "_mem_we"}, {31'h0, mem_we}, 32'd0);
    check({tagname, "_wstrb"}, {28'h0, mem_wstrb}, 32'd0);
    check({tagname, "_rdata"}, cpu_rdata, 32'd0);
  endtask

  // Abort a fill in its second beat with a one-cycle reset
  task automatic reset_mid_fill(input logic [31:0] addr);
    bit seen;
    ready_mode = 0;
    cpu_re = 1; cpu_we = 0; cpu_addr = addr; cpu_funct3 = 3'b010;
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk); #3;
      if (rd_log.size() >= 1) seen = 1;
    end
    check("abort_first_beat_seen", {31'h0, seen}, 32'd1);
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk); #3;
    check_quiet("abort_rst");
    check("abort_single_beat", 32'(rd_log.size()), 32'd1);
    @(posedge clk); #1;
    rst = 0;
    cpu_re = 0;
    rd_log.delete();
    for (int i = 0; i < 64; i++) ref_valid[i] = 0;
    @(negedge clk); #3;
    check("post_abort_mem_req", {31'h0, mem_req}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  ld_f3 [8];
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    for (int i = 0; i < 64; i++) ref_valid[i] = 0;
    mem_arr[32'h100] = 32'h1122_3344; ref_mem[32'h100] = 32'h1122_3344;
    mem_arr[32'h104] = 32'h5566_7788; ref_mem[32'h104] = 32'h5566_7788;
    mem_arr[32'h108] = 32'h99AA_BBCC; ref_mem[32'h108] = 32'h99AA_BBCC;
    mem_arr[32'h10C] = 32'hDDEE_FF00; ref_mem[32'h10C] = 32'hDDEE_FF00;
    rst = 1; cpu_re = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_funct3 = 0;
    repeat (2) @(posedge clk);
    cpu_re = 1; cpu_addr = 32'h100;
    @(negedge clk); #3;
    check_quiet("reset");
    @(posedge clk); #1;
    rst = 0; cpu_re = 0;
    @(negedge clk); #3;
    check("idle_mem_req", {31'h0, mem_req}, 32'd0);
    check("idle_stall", {31'h0, stall}, 32'd0);
    @(posedge clk); #1;

    // Cold fill then hits with every extension flavour
    ready_mode = 0;
    do_op(0, 32'h100, 3'b010, 0);
    do_op(0, 32'h101, 3'b000, 0);
    do_op(0, 32'h10B, 3'b000, 0);
    do_op(0, 32'h10B, 3'b100, 0);
    do_op(0, 32'h10A, 3'b001, 0);
    do_op(0, 32'h106, 3'b101, 0);
    // Byte store hit with slow memory, then readback
    ready_mode = 1;
    do_op(1, 32'h102, 3'b000, 32'h0000_00A5);
    do_op(0, 32'h100, 3'b010, 0);
    // Store miss does not allocate
    ready_mode = 0;
    do_op(1, 32'h2000, 3'b010, 32'hCAFE_F00D);
    do_op(0, 32'h2000, 3'b010, 0);
    // Conflict eviction on the same index
    do_op(0, 32'h500, 3'b010, 0);
    do_op(0, 32'h100, 3'b010, 0);
    // Reset during a fill, then a clean refill from word 0
    reset_mid_fill(32'h300);
    do_op(0, 32'h300, 3'b010, 0);

    // Random traffic over a few conflicting lines
    for (int i = 0; i < 300; i++) begin
      ready_mode = $urandom_range(0, 2);
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(16, 19)) << 4)
          | 32'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) do_op(1, a, 3'($urandom_range(0, 2)), $urandom);
      else do_op(0, a, ld_f3[$urandom_range(0, 7)], 0);
      if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the core's memory stage and the byte-addressed data memory.
- Serves LB/LH/LW/LBU/LHU hits in the same cycle.
- Fills 4-word lines from backing memory over a ready/valid word interface.
- Stalls the pipeline during misses and write-throughs.

Parameters:
ADDRESS_WIDTH, 32, byte address width
DATA_WIDTH, 32, word width (fixed at 32)
INDEX_BITS, 6, log2 of the number of sets (64 sets x 16 B = 1 KiB)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
cpu_re  in  1  load request
cpu_we  in  1  store request
cpu_addr  in  ADDRESS_WIDTH  byte address
cpu_wdata  in  32  store data, LSB-aligned
cpu_funct3  in  3  RISC-V load/store funct3
cpu_rdata  out  32  extended load result
stall  out  1  core must hold request and pipeline
mem_req  out  1  backing-memory request valid
mem_we  out  1  request is a write
mem_addr  out  ADDRESS_WIDTH  word-aligned address ([1:0]=0)
mem_wdata  out  32  write word, little-endian lanes
mem_wstrb  out  4  byte enables
mem_rdata  in  32  read word
mem_ready  in  1  accepts/completes current request this cycle

Behaviour:
- Address split:
  - byte offset [1:0]
  - word select [3:2]
  - index [INDEX_BITS+3:4]
  - tag: remaining upper bits
- Storage: per set, a valid bit, a tag, and 4 words. Little-endian; byte n of a word sits at lane [8n+7:8n].
- Alignment:
  - word access ignores addr[1:0]
  - halfword uses addr[1] and ignores addr[0]
  - byte uses addr[1:0]
- Load extension:
  - 000 sign-extends byte; 001 sign-extends halfword
  - 100 zero-extends byte; 101 zero-extends halfword
  - 010 and all other codes return the full word
- Store width: 000 byte, 001 halfword, all others word.
- cpu_we takes precedence when cpu_re and cpu_we are both high; the read is ignored.
- FSM states: IDLE, FILL, WRITE.
- IDLE:
  - Read hit (valid && tag match): cpu_rdata valid combinationally, stall=0, zero latency.
  - Read miss: stall=1 combinationally; next state FILL; word counter cleared.
  - Store (hit or miss): stall=1 combinationally; next state WRITE.
  - No request: stall=0, mem_req=0.
- FILL:
  - mem_req=1, mem_we=0, mem_addr={tag,index,cnt,2'b00}, cnt runs 0..3.
  - On each mem_ready, mem_rdata is written to word cnt and cnt increments.
  - After the 4th ready: set valid, write tag, go to IDLE.
  - The next cycle is a hit and stall drops.
  - Worst-case read miss equals 4 memory handshakes plus 1 cycle.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr = word address.
  - mem_wdata = store data replicated to the target lanes; mem_wstrb = 0001<<addr[1:0] (byte), 0011<<{addr[1],0} (half), or 1111 (word).
  - On mem_ready:
    - hit: cached word updated under the same strobes
    - miss: no allocation
    - return to IDLE with stall=0 that cycle
- Handshake:
  - mem_req, mem_addr, mem_we, mem_wdata and mem_wstrb are held stable until mem_ready.
  - mem_ready while mem_req=0 is ignored.
  - At most one outstanding request.
- Core contract: the core holds cpu_* stable while stall=1. The cache samples request fields from cpu_* directly, with no internal request latch.
- Reset (synchronous):
  - all valid bits cleared in one cycle; tags and data are not reset
  - state IDLE, cnt=0
  - during rst: mem_req=0, mem_we=0, mem_wstrb=0, stall=0, cpu_rdata=0
- Reset mid-FILL: fill aborted, line left invalid, mem_req low from the cycle rst is sampled.
- Reset mid-WRITE: request is dropped; the memory side must tolerate the abandoned request.
- Invalid lines never hit, even on a tag match.

Decomposition:
- Shared package cache_pkg holds:
  - enum cache_state_t {IDLE, FILL, WRITE}
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU
  - address-field width localparams
- Sub-module load_align (combinational) takes {word, addr[1:0], funct3} and returns the extended load data.
- Also reusable for an uncached path.

Test Plan:
- Cold read, addr 0x0000_0100, memory words 0x11223344/0x55667788/0x99AABBCC/0xDDEEFF00, mem_ready every cycle:
  - 4 reads at 0x100, 0x104, 0x108, 0x10C
  - stall high 5 cycles
  - then LW returns 0x11223344 with stall=0
- Hit extension on the same line:
  - LB 0x101 -> 0x00000033
  - LB 0x10B -> 0xFFFFFF99
  - LBU 0x10B -> 0x00000099
  - LH 0x10A -> 0xFFFF99AA
  - LHU 0x106 -> 0x00005566
  - all with zero stall
- SB 0x102 data 0xA5 on a hit line:
  - mem_wstrb=0100, mem_wdata[23:16]=0xA5
  - stall until ready (3-cycle ready delay)
  - following LW 0x100 -> 0x11A53344
- SW miss at 0x2000:
  - one memory write; valid unchanged
  - next LW 0x2000 triggers a full FILL
- Conflict: read 0x0100 then 0x0500 (same index, different tag) evicts the first; a re-read of 0x0100 misses again.
- rst asserted in the 2nd FILL beat:
  - mem_req low next cycle, stall=0
  - a later read of the same address re-fills from word 0.
